// File: rtl/spi_mem_ctrl.sv
// Single-request SPI RAM controller: one 40-bit mode-0 frame per CPU word access.
// Latency: rsp_valid in the 83rd cycle after acceptance. Backpressure: req_ready only in IDLE.
module spi_mem_ctrl #(
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [14:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy_o,
    output logic        mem_csb_o,
    output logic        mem_sclk_o,
    output logic        mem_out_o,
    input  logic        mem_in_i
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_cnt;
    logic [39:0] r_shift;
    logic [15:0] r_rx;
    logic [15:0] r_rdata;
    logic        r_we;
    logic        r_rdy;
    logic        r_csb;
    logic        r_sclk;
    logic        r_valid;
    logic        w_accept;
    logic        w_last;

    assign w_accept = (r_state == IDLE) && r_rdy && req_valid;
    assign w_last   = (r_cnt == 7'd79);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SETUP;
            SETUP:   w_next = SHIFT;
            SHIFT:   if (w_last) w_next = HOLD;
            HOLD:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pin registers are loaded from the next state so each pin value lines up with its state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 7'd0;
            r_shift <= 40'd0;
            r_rx    <= 16'd0;
            r_rdata <= 16'd0;
            r_we    <= 1'b0;
            r_rdy   <= 1'b0;
            r_csb   <= 1'b1;
            r_sclk  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_rdy   <= (w_next == IDLE);
            r_csb   <= !(w_next inside {SETUP, SHIFT, HOLD});
            r_valid <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_shift <= {req_we ? CMD_WRITE : CMD_READ, req_addr, 1'b0,
                                    req_we ? req_wdata : 16'h0000};
                        r_cnt   <= 7'd0;
                    end
                end
                SETUP: begin
                    r_sclk <= 1'b1;
                    r_rx   <= {r_rx[14:0], mem_in_i};
                    r_cnt  <= 7'd0;
                end
                SHIFT: begin
                    if (w_last) begin
                        r_sclk  <= 1'b0;
                        r_shift <= 40'd0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                        if (!r_cnt[0]) begin
                            r_sclk  <= 1'b0;
                            r_shift <= {r_shift[38:0], 1'b0};
                        end else begin
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[14:0], mem_in_i};
                        end
                    end
                end
                HOLD: begin
                    // The last 16 samples are exactly the data field of the frame.
                    if (!r_we) r_rdata <= r_rx;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = r_rdy;
    assign rsp_valid  = r_valid;
    assign rsp_rdata  = r_rdata;
    assign busy_o     = (r_state != IDLE);
    assign mem_csb_o  = r_csb;
    assign mem_sclk_o = r_sclk;
    assign mem_out_o  = r_shift[39];

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: SPI RAM slave model, reference memory model and response scoreboard.
module tb_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [14:0] req_addr = 15'd0;
    logic [15:0] req_wdata = 16'd0;
    logic        req_ready, rsp_valid, busy_o, mem_csb_o, mem_sclk_o, mem_out_o;
    logic [15:0] rsp_rdata;
    logic        mem_in_i = 1'b0;

    spi_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy_o(busy_o),
        .mem_csb_o(mem_csb_o), .mem_sclk_o(mem_sclk_o), .mem_out_o(mem_out_o),
        .mem_in_i(mem_in_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] frame;
        logic [15:0] rdata;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [14:0] a);
        return ({1'b0, a} * 16'h03b1) ^ 16'h5a5a;
    endfunction

    // Reference model: word memory plus the last read value (rsp_rdata holds across writes).
    logic [15:0] ref_mem [logic [14:0]];
    logic [15:0] last_rd = 16'd0;

    function automatic logic [15:0] ref_read(input logic [14:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic push_exp(input bit we, input logic [14:0] a, input logic [15:0] d, input int acc);
        exp_t e;
        e.frame = {we ? 8'h02 : 8'h03, a, 1'b0, we ? d : 16'h0000};
        if (we) ref_mem[a] = d;
        else    last_rd = ref_read(a);
        e.rdata = last_rd;
        e.acc   = acc;
        exp_q.push_back(e);
    endtask

    // External SPI RAM: decodes MOSI, serves read data on MISO, commits writes at frame end.
    logic [15:0] ram [logic [14:0]];
    int          n_bits = 0, gap = 0, done_bits = 0;
    logic [39:0] mosi_sr = '0, done_frame = '0, miso_junk = '0;
    logic [15:0] rd_word = '0;
    logic        prev_sclk = 1'b0, prev_csb = 1'b1;
    bit          had_frame = 0, bad_sclk = 0, is_read = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            n_bits = 0; prev_sclk = 1'b0; prev_csb = 1'b1; had_frame = 0;
            gap = 0; bad_sclk = 0; mem_in_i = 1'b0; is_read = 0;
        end else begin
            if (mem_csb_o && mem_sclk_o) bad_sclk = 1;
            if (!mem_csb_o && prev_csb) begin
                if (had_frame) check("csb_gap_min2", 64'(gap >= 2), 64'd1);
                n_bits = 0; mosi_sr = '0; is_read = 0;
                miso_junk = {$urandom, $urandom};
            end
            if (!mem_csb_o) begin
                if (mem_sclk_o && !prev_sclk) begin
                    mosi_sr = {mosi_sr[38:0], mem_out_o};
                    n_bits++;
                    if (n_bits == 24 && mosi_sr[23:16] == 8'h03) begin
                        is_read = 1;
                        rd_word = ram.exists(mosi_sr[15:1]) ? ram[mosi_sr[15:1]] : init_val(mosi_sr[15:1]);
                    end
                end
                if (is_read && n_bits >= 24 && n_bits < 40) mem_in_i = rd_word[39 - n_bits];
                else                                         mem_in_i = miso_junk[n_bits % 40];
                gap = 0;
            end else begin
                gap++;
                if (!prev_csb) begin
                    done_frame = mosi_sr;
                    done_bits  = n_bits;
                    had_frame  = 1;
                    if (n_bits == 40 && mosi_sr[39:32] == 8'h02) ram[mosi_sr[31:17]] = mosi_sr[15:0];
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_latency", 64'(cyc - e.acc), 64'd82);
                    check("mosi_frame", 64'(done_frame), 64'(e.frame));
                    check("sclk_count", 64'(done_bits), 64'd40);
                    check("sclk_quiet_csb_high", 64'(bad_sclk), 64'd0);
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                end
                bad_sclk = 0;
            end
            prev_sclk = mem_sclk_o;
            prev_csb  = mem_csb_o;
        end
    end

    task automatic issue(input bit we, input logic [14:0] a, input logic [15:0] d,
                         input bit hold, output int acc);
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 300 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: req_ready=%0b, expected 1", req_ready);
            req_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            push_exp(we, a, d, acc);
            @(posedge clk);
            #1;
            if (!hold) req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_pins();
        check("rst_csb", 64'(mem_csb_o), 64'd1);
        check("rst_sclk", 64'(mem_sclk_o), 64'd0);
        check("rst_mosi", 64'(mem_out_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #3 rst_n = 1'b1;
        #1 check("ready_before_edge", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 check("ready_after_release", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int acc1, acc2;
        #22;
        check_reset_pins();
        release_reset();

        // Directed write then read of the top word.
        issue(1'b1, 15'h0005, 16'h1234, 1'b0, acc1);
        drain();
        ram[15'h7FFF]     = 16'hBEEF;
        ref_mem[15'h7FFF] = 16'hBEEF;
        issue(1'b0, 15'h7FFF, 16'hFFFF, 1'b0, acc1);
        drain();

        // Reset in SHIFT cycle 30 aborts the frame; nothing may complete afterwards.
        issue(1'b0, 15'h0123, 16'h0000, 1'b0, acc1);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_pins();
        void'(exp_q.pop_back());
        last_rd = 16'd0;
        release_reset();
        repeat (100) @(negedge clk);
        issue(1'b0, 15'h0123, 16'h0000, 1'b0, acc1);
        drain();

        // Held req_valid: two reads, address changed during the first frame.
        issue(1'b0, 15'h0005, 16'h0000, 1'b1, acc1);
        repeat (20) @(negedge clk);
        issue(1'b0, 15'h2A2A, 16'h5555, 1'b0, acc2);
        check("b2b_accept_spacing", 64'(acc2 - acc1), 64'd84);
        drain();

        // Random mix, addresses biased to a small window so reads hit earlier writes.
        for (int n = 0; n < 30; n++) begin
            bit          we;
            logic [14:0] a;
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) == 1) ? 15'($urandom_range(0, 7)) : 15'($urandom);
            issue(we, a, 16'($urandom), 1'b0, acc1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 SHALL have parameter CMD_READ, default 8'h03, SPI RAM read opcode.
REQ-002 SHALL have parameter CMD_WRITE, default 8'h02, SPI RAM write opcode.
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  CPU memory request present.
REQ-006 SHALL have port req_ready  out  1  controller can accept a request.
REQ-007 SHALL have port req_we  in  1  1=write, 0=read.
REQ-008 SHALL have port req_addr  in  15  Hack word address.
REQ-009 SHALL have port req_wdata  in  16  write data.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse, for reads and writes.
REQ-011 SHALL have port rsp_rdata  out  16  read data, valid while rsp_valid=1 and held until the next read completes.
REQ-012 SHALL have port busy_o  out  1  high whenever the state is not IDLE.
REQ-013 SHALL have port mem_csb_o  out  1  SPI chip select, active-low.
REQ-014 SHALL have port mem_sclk_o  out  1  SPI clock, mode 0.
REQ-015 SHALL have port mem_out_o  out  1  SPI MOSI.
REQ-016 SHALL have port mem_in_i  in  1  SPI MISO.

Function
REQ-017 SHALL register all SPI outputs; no combinational path from any input to any SPI output.
REQ-018 SHALL implement states IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-019 SHALL assert req_ready only in IDLE; acceptance occurs on an edge where req_valid=1 and req_ready=1.
REQ-020 SHALL, on acceptance, latch req_we, req_addr and req_wdata; later input changes SHALL not affect the transaction.
REQ-021 SHALL ignore req_valid in every state other than IDLE.
REQ-022 SHALL form a 40-bit frame {opcode[7:0], byte_addr[15:0], data[15:0]}.
REQ-023 SHALL set byte_addr = {req_addr, 1'b0}.
REQ-024 SHALL set the frame data field to req_wdata for writes and to 16'h0000 for reads.
REQ-025 SHALL shift the frame MSB first.
REQ-026 SHALL, in SETUP (1 cycle), drive csb=0, sclk=0 and mem_out=frame bit 39.
REQ-027 SHALL, in SHIFT, take 2 cycles per bit, 80 cycles total: a high cycle with sclk=1 followed by a low cycle with sclk=0, during which mem_out advances to the next bit.
REQ-028 SHALL sample mem_in_i on the edge that drives sclk 0->1.
REQ-029 SHALL use samples 25..40 (the data field) as rsp_rdata[15:0], MSB first.
REQ-030 SHALL, in HOLD (1 cycle), drive csb=0, sclk=0 and mem_out=0.
REQ-031 SHALL, in DONE (1 cycle), drive csb=1 and rsp_valid=1, update rsp_rdata for reads only, and return to IDLE.
REQ-032 SHALL assert rsp_valid exactly 83 cycles after the acceptance edge.
REQ-033 SHALL keep csb high for at least 2 cycles between frames (DONE plus IDLE).
REQ-034 SHALL support back-to-back requests: with req_valid held high, the next acceptance occurs on the first IDLE cycle.
REQ-035 SHALL hold sclk low whenever csb=1.
REQ-036 SHALL use an internal bit counter wide enough for 0..79 with no wrap-around; the SHIFT->HOLD transition occurs after the 80th SHIFT cycle.

Reset
REQ-037 SHALL, while rst_n=0, asynchronously force state=IDLE, mem_csb_o=1, mem_sclk_o=0, mem_out_o=0, rsp_valid=0, rsp_rdata=0, busy_o=0 and req_ready=0.
REQ-038 SHALL assert req_ready=1 on the first edge after reset release.
REQ-039 SHALL, on reset during any state, abort the frame with csb rising immediately and produce no rsp_valid pulse.

Verification
REQ-040 Bench SHALL cover: assert rst_n=0 -> csb=1, sclk=0, mosi=0, rsp_valid=0, rsp_rdata=0; release -> req_ready=1 next cycle.
REQ-041 Bench SHALL cover: write addr 15'h0005, data 16'h1234 -> MOSI stream 0x02, 0x000A, 0x1234 on 40 sclk rising edges; rsp_valid at cycle 83; rsp_rdata unchanged.
REQ-042 Bench SHALL cover: read addr 15'h7FFF with the SPI model returning 16'hBEEF -> MOSI 0x03, 0xFFFE, 0x0000; rsp_rdata=16'hBEEF with rsp_valid at cycle 83.
REQ-043 Bench SHALL cover: rst_n pulsed low at SHIFT cycle 30 -> csb=1 asynchronously, no rsp_valid; a following read completes correctly.
REQ-044 Bench SHALL cover: req_valid held high for two reads, with req_addr changed mid-frame -> first frame uses the latched address, csb high for 2 cycles, second frame starts at once.
REQ-045 Bench SHALL cover: throughout all tests, check the sclk count per frame is 40 and that sclk never toggles while csb=1.
